// File: rtl/des_core_arbiter.sv
// Round-robin front end for a single shared DES core: one job in flight, watchdog
// abort with a two-cycle core reset, tagged valid/ready response and job statistics.
module des_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*64-1:0]   req_message,
    input  logic [NUM_REQ*768-1:0]  req_round_keys,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    core_start,
    output logic                    core_rst_n,
    output logic [63:0]             core_message,
    output logic [767:0]            core_round_keys,
    input  logic                    core_done,
    input  logic [63:0]             core_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [63:0]             rsp_result,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [15:0]             jobs_done,
    output logic [7:0]              timeouts
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RECOVER, S_RESP} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     rr_q;
    logic [ID_W-1:0]     g_q;
    logic [CNT_W-1:0]    wdog_q;
    logic                rec_cnt_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic                core_start_q;
    logic                core_rst_n_q;
    logic [63:0]         core_message_q;
    logic [767:0]        core_round_keys_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [63:0]         rsp_result_q;
    logic                rsp_err_q;
    logic                busy_q;
    logic [15:0]         jobs_done_q;
    logic [7:0]          timeouts_q;

    logic                grant_vld_d;
    logic [ID_W-1:0]     grant_d;

    logic [63:0]  msg_arr [NUM_REQ];
    logic [767:0] rk_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign msg_arr[gi] = req_message[gi*64 +: 64];
        assign rk_arr[gi]  = req_round_keys[gi*768 +: 768];
    end

    // Scan from the farthest candidate back to rr_q so the nearest set bit wins.
    always_comb begin : grant_sel
        logic [ID_W-1:0] idx;
        idx         = '0;
        grant_vld_d = 1'b0;
        grant_d     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
            if (req[idx]) begin
                grant_vld_d = 1'b1;
                grant_d     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            rr_q              <= '0;
            g_q               <= '0;
            wdog_q            <= '0;
            rec_cnt_q         <= 1'b0;
            ack_q             <= '0;
            core_start_q      <= 1'b0;
            core_rst_n_q      <= 1'b1;
            core_message_q    <= '0;
            core_round_keys_q <= '0;
            rsp_valid_q       <= 1'b0;
            rsp_id_q          <= '0;
            rsp_result_q      <= '0;
            rsp_err_q         <= 1'b0;
            busy_q            <= 1'b0;
            jobs_done_q       <= '0;
            timeouts_q        <= '0;
        end else begin
            ack_q        <= '0;
            core_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld_d) begin
                        core_message_q    <= msg_arr[grant_d];
                        core_round_keys_q <= rk_arr[grant_d];
                        ack_q             <= NUM_REQ'(1) << grant_d;
                        core_start_q      <= 1'b1;
                        g_q               <= grant_d;
                        busy_q            <= 1'b1;
                        state_q           <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        rsp_result_q <= core_result;
                        rsp_err_q    <= 1'b0;
                        rsp_id_q     <= g_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (wdog_q == WDOG_LAST) begin
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        if (timeouts_q != 8'hFF) begin
                            timeouts_q <= timeouts_q + 8'd1;
                        end
                        core_rst_n_q <= 1'b0;
                        rec_cnt_q    <= 1'b0;
                        state_q      <= S_RECOVER;
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                    end
                end
                // Core held in reset for two cycles so a late done cannot leak into the next job.
                S_RECOVER: begin
                    if (rec_cnt_q) begin
                        core_rst_n_q <= 1'b1;
                        rsp_id_q     <= g_q;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        rec_cnt_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        jobs_done_q <= jobs_done_q + 16'd1;
                        rr_q        <= (g_q == ID_LAST) ? '0 : g_q + ID_W'(1);
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ack             = ack_q;
    assign core_start      = core_start_q;
    assign core_rst_n      = core_rst_n_q;
    assign core_message    = core_message_q;
    assign core_round_keys = core_round_keys_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign rsp_result      = rsp_result_q;
    assign rsp_err         = rsp_err_q;
    assign busy            = busy_q;
    assign jobs_done       = jobs_done_q;
    assign timeouts        = timeouts_q;

endmodule
